freq_meter_bcd: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 29 ++
 rtl/freq_meter_bcd.sv | 132 +++++++++++++
 tb/tb_freq_meter_bcd.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared widths, constants and digit type for the gated BCD frequency meter.
package freq_meter_pkg;

    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BCD_W      = BCD_DIGITS * DIGIT_W;
    localparam int unsigned GATE_W     = 32;

    localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_ZERO = DIGIT_W'(0);
    localparam bcd_digit_t DIGIT_ONE  = DIGIT_W'(1);
    localparam bcd_digit_t DIGIT_NINE = DIGIT_W'(9);

    // Decimal increment of one digit; 9 wraps to 0 (the carry is produced by the caller).
    function automatic bcd_digit_t digit_inc(input bcd_digit_t d);
        return (d == DIGIT_NINE) ? DIGIT_ZERO : bcd_digit_t'(d + DIGIT_ONE);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD accumulator: clear/preload, increment with carry-out, freeze on saturation.
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load1,
    input  logic       inc,
    input  logic       hold,
    output bcd_digit_t q,
    output logic       carry
);

    // Window restart wins over counting; hold keeps a saturated 9999 from wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= DIGIT_ZERO;
        end else if (clr) begin
            q <= load1 ? DIGIT_ONE : DIGIT_ZERO;
        end else if (inc && !hold) begin
            q <= digit_inc(q);
        end
    end

    // Ripple into the next decade when this one rolls over.
    assign carry = inc & (q == DIGIT_NINE);

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated frequency meter: counts sig_in rises per window and latches a 4-digit BCD result.
module freq_meter_bcd
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic             valid,
    output logic             overflow
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              sync1;
    logic              sync2;
    logic              dly;
    logic              sig_edge;
    logic [GATE_W-1:0] gate_cnt;
    logic              gate_end;
    bcd_digit_t        q0, q1, q2, q3;
    logic              c0, c1, c2, c3;
    logic              sat_hit;
    logic [BCD_W-1:0]  acc;
    logic              sat;

    // Two-flop synchronizer plus a delay stage for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign sig_edge = sync2 & ~dly;

    // Free-running window counter; gate_end marks the last cycle of each window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
        end else if (gate_end) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
        end
    end

    assign gate_end = (gate_cnt == GATE_LAST);

    // The top-decade carry is set exactly when acc == BCD_MAX and an edge arrives.
    assign sat_hit = c3;

    bcd_digit u_d0 (
        .clk   (clk),
        .rst   (rst),
        .clr   (gate_end),
        .load1 (sig_edge),
        .inc   (sig_edge),
        .hold  (sat_hit),
        .q     (q0),
        .carry (c0)
    );

    bcd_digit u_d1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (gate_end),
        .load1 (1'b0),
        .inc   (c0),
        .hold  (sat_hit),
        .q     (q1),
        .carry (c1)
    );

    bcd_digit u_d2 (
        .clk   (clk),
        .rst   (rst),
        .clr   (gate_end),
        .load1 (1'b0),
        .inc   (c1),
        .hold  (sat_hit),
        .q     (q2),
        .carry (c2)
    );

    bcd_digit u_d3 (
        .clk   (clk),
        .rst   (rst),
        .clr   (gate_end),
        .load1 (1'b0),
        .inc   (c2),
        .hold  (sat_hit),
        .q     (q3),
        .carry (c3)
    );

    assign acc = {q3, q2, q1, q0};

    // Sticky saturation flag, cleared as each window closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat <= 1'b0;
        end else if (gate_end) begin
            sat <= 1'b0;
        end else if (sat_hit) begin
            sat <= 1'b1;
        end
    end

    // Publish the finished window; result and overflow hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= gate_end;
            if (gate_end) begin
                bcd_out  <= acc;
                overflow <= sat;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Self-checking bench for freq_meter_bcd: directed steps plus random trains against a window-count model.
module tb_freq_meter_bcd;

    localparam int G_SM  = 100;
    localparam int G_BIG = 40050;
    localparam int MAX_W = 64;

    logic        clk;
    logic        rst_sm, sig_sm, valid_sm, ovf_sm;
    logic        rst_big, sig_big, valid_big, ovf_big;
    logic [15:0] bcd_sm, bcd_big;

    int n_vec;
    int n_miss;

    // Reference model: sampled-input history per DUT, rises binned into windows.
    int n_edge  [2];
    bit prev_s  [2];
    int win_cnt [2][MAX_W];

    freq_meter_bcd #(.GATE_CYCLES(G_SM)) u_sm (
        .clk      (clk),
        .rst      (rst_sm),
        .sig_in   (sig_sm),
        .bcd_out  (bcd_sm),
        .valid    (valid_sm),
        .overflow (ovf_sm)
    );

    freq_meter_bcd #(.GATE_CYCLES(G_BIG)) u_big (
        .clk      (clk),
        .rst      (rst_big),
        .sig_in   (sig_big),
        .bcd_out  (bcd_big),
        .valid    (valid_big),
        .overflow (ovf_big)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset(input int id);
        n_edge[id] = 0;
        prev_s[id] = 1'b0;
        for (int i = 0; i < MAX_W; i++) win_cnt[id][i] = 0;
    endtask

    // A rise sampled at clock edge k is in the accumulator two edges later; window m
    // (reported at edge m*G) accumulates over edges (m-1)*G .. m*G-1.
    task automatic model_clock(input int id, input bit s, input int g);
        int m;
        n_edge[id]++;
        if (s && !prev_s[id]) begin
            m = (n_edge[id] + 2) / g + 1;
            if (m < MAX_W) win_cnt[id][m]++;
        end
        prev_s[id] = s;
    endtask

    always @(posedge clk or posedge rst_sm) begin
        if (rst_sm) model_reset(0);
        else        model_clock(0, sig_sm, G_SM);
    end

    always @(posedge clk or posedge rst_big) begin
        if (rst_big) model_reset(1);
        else         model_clock(1, sig_big, G_BIG);
    end

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int id, output logic [15:0] b, output logic v, output logic o);
        if (id == 0) begin
            b = bcd_sm;  v = valid_sm;  o = ovf_sm;
        end else begin
            b = bcd_big; v = valid_big; o = ovf_big;
        end
    endtask

    task automatic set_sig(input int id, input logic val);
        if (id == 0) sig_sm = val;
        else         sig_big = val;
    endtask

    // Wait (bounded) for the next valid pulse and compare it with the model's window count.
    task automatic expect_window(input int id, input string tag,
                                 output logic [15:0] b_out, output logic o_out, output int n_out);
        int         g;
        int         m;
        int         cnt;
        bit         seen;
        logic [15:0] b;
        logic        v, o;
        g    = (id == 0) ? G_SM : G_BIG;
        seen = 1'b0;
        b = '0; v = 1'b0; o = 1'b0;
        for (int i = 0; i < g + 8; i++) begin
            @(posedge clk);
            #1;
            get_obs(id, b, v, o);
            if (v) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " valid seen"}, 32'(seen), 32'd1);
        b_out = b;
        o_out = o;
        n_out = n_edge[id];
        if (seen) begin
            m   = n_edge[id] / g;
            cnt = (m < MAX_W) ? win_cnt[id][m] : -1;
            check({tag, " timing"}, 32'(n_edge[id] % g), 32'd0);
            check({tag, " bcd"}, 32'(b), 32'(to_bcd(cnt)));
            check({tag, " ovf"}, 32'(o), 32'(cnt > 9999));
            @(posedge clk);
            #1;
            get_obs(id, b, v, o);
            check({tag, " valid 1-cycle"}, 32'(v), 32'd0);
            check({tag, " bcd hold"}, 32'(b), 32'(b_out));
        end
    endtask

    task automatic square(input int id, input int n, input int half);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            set_sig(id, 1'b1);
            repeat (half) @(negedge clk);
            set_sig(id, 1'b0);
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic rand_train(input int id, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            set_sig(id, 1'b1);
            repeat ($urandom_range(2, 6)) @(negedge clk);
            set_sig(id, 1'b0);
            repeat ($urandom_range(2, 6)) @(negedge clk);
        end
    endtask

    // Make the input high so that it is first sampled at clock edge k, for two cycles.
    task automatic drive_rise_at(input int id, input int k);
        @(negedge clk);
        while (n_edge[id] < k - 1) @(negedge clk);
        set_sig(id, 1'b1);
        repeat (2) @(negedge clk);
        set_sig(id, 1'b0);
    endtask

    initial begin
        logic [15:0] b;
        logic        o;
        int          n;
        int          base;

        n_vec  = 0;
        n_miss = 0;
        rst_sm = 1'b1; rst_big = 1'b1;
        sig_sm = 1'b0; sig_big = 1'b0;
        repeat (3) @(negedge clk);

        check("rst bcd_sm",   32'(bcd_sm),    32'd0);
        check("rst valid_sm", 32'(valid_sm),  32'd0);
        check("rst ovf_sm",   32'(ovf_sm),    32'd0);
        check("rst bcd_big",  32'(bcd_big),   32'd0);
        check("rst valid_big",32'(valid_big), 32'd0);
        check("rst ovf_big",  32'(ovf_big),   32'd0);

        // Idle input: empty windows at 100, 200, 300 cycles after release.
        rst_sm = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            expect_window(0, "idle", b, o, n);
            check("idle cycle", 32'(n), 32'(G_SM * w));
            check("idle zero", 32'(b), 32'h0000);
        end

        // Period-8 square wave: a full window sees 12 or 13 rises depending on phase.
        fork
            square(0, 50, 4);
            begin
                expect_window(0, "p8 w1", b, o, n);
                expect_window(0, "p8 w2", b, o, n);
                check("p8 steady range", 32'(b == 16'h0012 || b == 16'h0013), 32'd1);
                expect_window(0, "p8 w3", b, o, n);
            end
        join
        expect_window(0, "p8 tail", b, o, n);

        // Period-4 square wave: exactly 25 rises per full window, exercising units->tens carry.
        fork
            square(0, 75, 2);
            begin
                expect_window(0, "p4 w1", b, o, n);
                expect_window(0, "p4 w2", b, o, n);
                check("p4 steady", 32'(b), 32'h0025);
                expect_window(0, "p4 w3", b, o, n);
            end
        join
        expect_window(0, "p4 tail", b, o, n);

        // Boundary: the fourth rise lands in the gate_end cycle and belongs to the next window.
        base = n;
        drive_rise_at(0, base + 10);
        drive_rise_at(0, base + 30);
        drive_rise_at(0, base + 50);
        drive_rise_at(0, base + G_SM - 2);
        expect_window(0, "bnd pre", b, o, n);
        check("bnd pre count", 32'(b), 32'h0003);
        expect_window(0, "bnd post", b, o, n);
        check("bnd post count", 32'(b), 32'h0001);

        // Mid-window reset after 5 rises: outputs clear at once, next window starts clean.
        base = n;
        for (int i = 0; i < 5; i++) drive_rise_at(0, base + 5 + 5 * i);
        @(negedge clk);
        rst_sm = 1'b1;
        #1;
        check("mid rst bcd",   32'(bcd_sm),   32'd0);
        check("mid rst valid", 32'(valid_sm), 32'd0);
        check("mid rst ovf",   32'(ovf_sm),   32'd0);
        repeat (3) @(negedge clk);
        rst_sm = 1'b0;
        expect_window(0, "post rst", b, o, n);
        check("post rst cycle", 32'(n), 32'(G_SM));
        check("post rst zero", 32'(b), 32'h0000);

        // Five one-cycle pulses, one sub-cycle glitch over an edge, one between edges: 6 counts.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sig_sm = 1'b1;
            @(negedge clk);
            sig_sm = 1'b0;
            repeat (3) @(negedge clk);
        end
        #3 sig_sm = 1'b1;
        #4 sig_sm = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 sig_sm = 1'b1;
        #2 sig_sm = 1'b0;
        expect_window(0, "narrow", b, o, n);
        check("narrow count", 32'(b), 32'h0006);

        // Random legal-rate trains against the model.
        fork
            rand_train(0, 45);
            begin
                for (int w = 0; w < 4; w++) expect_window(0, "rand", b, o, n);
            end
        join

        // Large window: more than 9999 rises saturates; exactly 9999 does not.
        @(negedge clk);
        rst_big = 1'b0;
        square(1, 10005, 2);
        expect_window(1, "sat", b, o, n);
        check("sat bcd", 32'(b), 32'h9999);
        check("sat ovf", 32'(o), 32'd1);
        square(1, 3, 2);
        @(negedge clk);
        rst_big = 1'b1;
        #1;
        check("big rst bcd",   32'(bcd_big),   32'd0);
        check("big rst ovf",   32'(ovf_big),   32'd0);
        check("big rst valid", 32'(valid_big), 32'd0);
        repeat (2) @(negedge clk);
        rst_big = 1'b0;
        square(1, 9999, 2);
        expect_window(1, "full", b, o, n);
        check("full bcd", 32'(b), 32'h9999);
        check("full ovf", 32'(o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
